// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - game-core to seven-segment scanner signal bundle
// Optional BRIGHTNESS_PWM_EN adds the brightness_in member.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
`ifdef BRIGHTNESS_PWM_EN
    logic [3:0]              brightness_in;
`endif
    logic [NUM_DIGITS-1:0]   Anodes;
    logic [7:0]              Cathodes;
    logic [3:0]              digit_idx;
    logic                    frame_tick;

    modport master (
`ifdef BRIGHTNESS_PWM_EN
        output brightness_in,
`endif
        output enable, load, digits_in, dp_in, blank_in,
        input  Anodes, Cathodes, digit_idx, frame_tick
    );

    modport slave (
`ifdef BRIGHTNESS_PWM_EN
        input  brightness_in,
`endif
        input  enable, load, digits_in, dp_in, blank_in,
        output Anodes, Cathodes, digit_idx, frame_tick
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - double-buffered, dead-timed multiplexed seven-segment scanner
// Optional BRIGHTNESS_PWM_EN gates each lit slot with a 16-phase brightness PWM.
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 100000,
    parameter int DEAD_CYCLES    = 1000,
    parameter bit ACTIVE_LOW_OUT = 1'b1
) (
    input  logic              CLK100MHZ,
    input  logic              reset_n,
    seg7_scan_driver_if.slave bus
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SW-1:0] LAST_SLOT  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] DEAD_END   = SW'(DEAD_CYCLES);
    localparam logic [3:0]    LAST_DIGIT = 4'(NUM_DIGITS - 1);

    logic [SW-1:0]         slot_cnt;
    logic [3:0]            digit_q;
    logic [3:0]            pend_digits [NUM_DIGITS];
    logic [3:0]            disp_digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] pend_dp, pend_blank, disp_dp, disp_blank;
    logic [NUM_DIGITS-1:0] an_q;
    logic [7:0]            cat_q;

    logic                  frame_wrap, lit, pwm_ok;
    logic [DW-1:0]         cur;
    logic [NUM_DIGITS-1:0] onehot;
    logic [6:0]            seg;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    assign frame_wrap = bus.enable && (slot_cnt == LAST_SLOT) && (digit_q == LAST_DIGIT);
    assign cur        = digit_q[DW-1:0];

`ifdef BRIGHTNESS_PWM_EN
    logic [3:0]    bright_q;
    logic [SW+3:0] pwm_phase;
    assign pwm_phase = {4'b0, slot_cnt} - {4'b0, DEAD_END};
    assign pwm_ok    = pwm_phase[3:0] < bright_q;

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n)        bright_q <= 4'd0;
        else if (frame_wrap) bright_q <= bus.brightness_in;
    end
`else
    assign pwm_ok = 1'b1;
`endif

    always_comb begin
        lit    = bus.enable && (slot_cnt >= DEAD_END) && !disp_blank[cur] && pwm_ok;
        onehot = NUM_DIGITS'(1) << cur;
        seg    = hex7(disp_digits[cur]);
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt   <= '0;
            digit_q    <= 4'd0;
            pend_dp    <= '0;
            pend_blank <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
            an_q       <= '0;
            cat_q      <= 8'd0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                pend_digits[i] <= 4'd0;
                disp_digits[i] <= 4'd0;
            end
        end else begin
            if (bus.enable) begin
                if (slot_cnt == LAST_SLOT) begin
                    slot_cnt <= '0;
                    digit_q  <= (digit_q == LAST_DIGIT) ? 4'd0 : digit_q + 4'd1;
                end else begin
                    slot_cnt <= slot_cnt + 1'b1;
                end
            end
            if (bus.load) begin
                pend_dp    <= bus.dp_in;
                pend_blank <= bus.blank_in;
                for (int i = 0; i < NUM_DIGITS; i++)
                    pend_digits[i] <= bus.digits_in[4*i +: 4];
            end
            // A load coinciding with the wrap bypasses pending so it shows this frame.
            if (frame_wrap) begin
                disp_dp    <= bus.load ? bus.dp_in : pend_dp;
                disp_blank <= bus.load ? bus.blank_in : pend_blank;
                for (int i = 0; i < NUM_DIGITS; i++)
                    disp_digits[i] <= bus.load ? bus.digits_in[4*i +: 4] : pend_digits[i];
            end
            an_q  <= lit ? onehot : '0;
            cat_q <= lit ? {disp_dp[cur], seg} : 8'd0;
        end
    end

    assign bus.Anodes     = an_q ^ {NUM_DIGITS{ACTIVE_LOW_OUT}};
    assign bus.Cathodes   = cat_q ^ {8{ACTIVE_LOW_OUT}};
    assign bus.digit_idx  = digit_q;
    assign bus.frame_tick = frame_wrap;
endmodule
